// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding and load-use hazard control for a
// classic five-stage in-order pipeline. Shadows the EX/MEM/WB stage
// bookkeeping, produces registered forwarding selects for the instruction in
// EX and a combinational load-use stall for the instruction in ID.
//
// Optional feature: define FWD_STALL_CNT_EN to add a saturating 32-bit
// stall_cnt output counting non-held cycles with stall asserted.
module fwd_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       hold,
  input  logic       flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;  // MEM/WB result
  localparam logic [1:0] SEL_EX  = 2'b10;  // EX/MEM result

  // Shadow stage bookkeeping
  logic       ex_valid;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       ex_regwrite;
  logic       ex_memread;
  logic [4:0] mem_rd;
  logic       mem_regwrite;
  logic [4:0] wb_rd;
  logic       wb_regwrite;

  logic       load_ex;
  logic       ex_fwd_ok;
  logic       mem_fwd_ok;
  logic [1:0] sel_a_nxt;
  logic [1:0] sel_b_nxt;

  // A load in EX cannot forward yet; its consumer must wait one cycle.
  // Flush wins because the ID instruction is being killed anyway.
  always_comb begin
    stall = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
            ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush;
  end

  // Producer qualifiers; x0 is hard-wired zero and is never forwarded.
  assign ex_fwd_ok  = ex_regwrite & (ex_rd != 5'd0) & ~ex_memread;
  assign mem_fwd_ok = mem_regwrite & (mem_rd != 5'd0);
  assign load_ex    = ~stall & ~flush;

  // Next-cycle selects for the ID instruction; the newer EX producer wins.
  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned and infers a latch.
  always_comb begin
    sel_a_nxt = SEL_RF;
    sel_b_nxt = SEL_RF;
    if (ex_fwd_ok && ex_rd == id_rs1)       sel_a_nxt = SEL_EX;
    else if (mem_fwd_ok && mem_rd == id_rs1) sel_a_nxt = SEL_MEM;
    if (ex_fwd_ok && ex_rd == id_rs2)       sel_b_nxt = SEL_EX;
    else if (mem_fwd_ok && mem_rd == id_rs2) sel_b_nxt = SEL_MEM;
  end

  // Advance the shadow pipeline on every non-held edge; a stall or flush
  // drops a bubble into EX, which also clears the selects.
  // NOTE: non-blocking assignments let every stage sample the pre-edge
  // value of its predecessor, which is what makes the shift a real shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rd        <= 5'd0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= 5'd0;
      mem_regwrite <= 1'b0;
      wb_rd        <= 5'd0;
      wb_regwrite  <= 1'b0;
      fwd_a_sel    <= SEL_RF;
      fwd_b_sel    <= SEL_RF;
    end else if (!hold) begin
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      if (load_ex) begin
        ex_valid    <= id_valid;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        fwd_a_sel   <= sel_a_nxt;
        fwd_b_sel   <= sel_b_nxt;
      end else begin
        ex_valid    <= 1'b0;
        ex_rs1      <= 5'd0;
        ex_rs2      <= 5'd0;
        ex_rd       <= 5'd0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        fwd_a_sel   <= SEL_RF;
        fwd_b_sel   <= SEL_RF;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating count of non-held stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (!hold && stall && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // Consistency: a select always points at the stage that now holds the
  // producer (it moved EX->MEM or MEM->WB on the edge that set the select).
  sel_legal: assert property (@(posedge clk) disable iff (!rst_n)
    fwd_a_sel != 2'b11 && fwd_b_sel != 2'b11);
  a_from_ex: assert property (@(posedge clk) disable iff (!rst_n)
    (fwd_a_sel == SEL_EX) |-> (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1));
  b_from_ex: assert property (@(posedge clk) disable iff (!rst_n)
    (fwd_b_sel == SEL_EX) |-> (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2));
  a_from_mem: assert property (@(posedge clk) disable iff (!rst_n)
    (fwd_a_sel == SEL_MEM) |-> (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1));
  b_from_mem: assert property (@(posedge clk) disable iff (!rst_n)
    (fwd_b_sel == SEL_MEM) |-> (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding selects, load-use stall,
// x0, hold, flush and asynchronous reset. Build with FWD_STALL_CNT_EN
// defined to also check the stall counter.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       hold;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fwd_hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .hold       (hold),
    .flush      (flush),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall      (stall)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present an instruction in ID.
  task automatic put(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rw, input logic mr);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    put(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic check_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
    check({tag, "_a"}, {30'd0, fwd_a_sel}, {30'd0, a});
    check({tag, "_b"}, {30'd0, fwd_b_sel}, {30'd0, b});
  endtask

`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt_base;
`endif

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    nop();
    #12;
    check_sel("reset_sel", 2'b00, 2'b00);
    check("reset_stall", {31'd0, stall}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    check("reset_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // EX-EX: add x5,x1,x2 ; sub x6,x5,x1
    put(1, 5'd1, 5'd2, 5'd5, 1, 0); tick();
    put(1, 5'd5, 5'd1, 5'd6, 1, 0); #1;
    check("exex_stall", {31'd0, stall}, 32'd0);
    tick();
    check_sel("exex", 2'b10, 2'b00);
    drain();

    // Priority: add x5 ; add x5 ; or x7,x5,x5 -> newest producer
    put(1, 5'd1, 5'd2, 5'd5, 1, 0); tick();
    put(1, 5'd3, 5'd4, 5'd5, 1, 0); tick();
    put(1, 5'd5, 5'd5, 5'd7, 1, 0); tick();
    check_sel("prio", 2'b10, 2'b10);
    drain();

    // MEM-EX: add x8 ; unrelated ; or x10,x8,x8
    put(1, 5'd1, 5'd2, 5'd8, 1, 0); tick();
    put(1, 5'd1, 5'd2, 5'd9, 1, 0); tick();
    put(1, 5'd8, 5'd8, 5'd10, 1, 0); tick();
    check_sel("memex", 2'b01, 2'b01);
    drain();

    // Load-use: lw x3 ; add x4,x3,x2
`ifdef FWD_STALL_CNT_EN
    cnt_base = stall_cnt;
`endif
    put(1, 5'd1, 5'd0, 5'd3, 1, 1); tick();
    put(1, 5'd3, 5'd2, 5'd4, 1, 0); #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    check_sel("lu_bubble", 2'b00, 2'b00);
    check("lu_stall_once", {31'd0, stall}, 32'd0);
    tick();
    check_sel("lu_use", 2'b01, 2'b00);
`ifdef FWD_STALL_CNT_EN
    check("lu_cnt", stall_cnt, cnt_base + 32'd1);
`endif
    drain();

    // x0: addi x0,x1 ; add x11,x0,x0
    put(1, 5'd1, 5'd0, 5'd0, 1, 0); tick();
    put(1, 5'd0, 5'd0, 5'd11, 1, 0); tick();
    check_sel("x0_alu", 2'b00, 2'b00);
    // lw x0 followed by a use of x0 must not stall
    put(1, 5'd1, 5'd0, 5'd0, 1, 1); tick();
    put(1, 5'd0, 5'd0, 5'd11, 1, 0); #1;
    check("x0_load_stall", {31'd0, stall}, 32'd0);
    drain();

    // Hold during a stall: add x14 ; lw x12,0(x14) ; add x13,x12,x12
    put(1, 5'd1, 5'd2, 5'd14, 1, 0); tick();
    put(1, 5'd14, 5'd0, 5'd12, 1, 1); tick();
    check_sel("hold_pre", 2'b10, 2'b00);
    put(1, 5'd12, 5'd12, 5'd13, 1, 0); #1;
    check("hold_pre_stall", {31'd0, stall}, 32'd1);
`ifdef FWD_STALL_CNT_EN
    cnt_base = stall_cnt;
`endif
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_stall%0d", i), {31'd0, stall}, 32'd1);
      check_sel($sformatf("hold%0d", i), 2'b10, 2'b00);
`ifdef FWD_STALL_CNT_EN
      check($sformatf("hold_cnt%0d", i), stall_cnt, cnt_base);
`endif
    end
    hold = 1'b0;
    tick();
    check_sel("hold_bubble", 2'b00, 2'b00);
    check("hold_post_stall", {31'd0, stall}, 32'd0);
    tick();
    check_sel("hold_use", 2'b01, 2'b01);
`ifdef FWD_STALL_CNT_EN
    check("hold_cnt_after", stall_cnt, cnt_base + 32'd1);
`endif
    drain();

    // Flush over stall: lw x3 in EX, add x4,x3,x3 in ID, flush
    put(1, 5'd1, 5'd0, 5'd3, 1, 1); tick();
    put(1, 5'd3, 5'd3, 5'd4, 1, 0);
    flush = 1'b1; #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    check_sel("flush_bubble", 2'b00, 2'b00);
    // killed add x4 never entered EX, so nothing forwards x4
    put(1, 5'd4, 5'd4, 5'd15, 1, 0); tick();
    check_sel("flush_killed", 2'b00, 2'b00);
    drain();

    // Reset mid-stall: add x20 ; lw x3,0(x20) ; add x4,x3,x3
    put(1, 5'd1, 5'd2, 5'd20, 1, 0); tick();
    put(1, 5'd20, 5'd0, 5'd3, 1, 1); tick();
    put(1, 5'd3, 5'd3, 5'd4, 1, 0); #1;
    check("rst_pre_stall", {31'd0, stall}, 32'd1);
    check_sel("rst_pre", 2'b10, 2'b00);
    rst_n = 1'b0; #1;
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check_sel("rst_mid", 2'b00, 2'b00);
`ifdef FWD_STALL_CNT_EN
    check("rst_mid_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_stall", {31'd0, stall}, 32'd0);
    tick();
    check_sel("rst_after", 2'b00, 2'b00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a runaway simulation.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
